// File: rtl/gpio_pio_pkg.sv
// Shared definitions for masters that talk to the 4-register GPIO PIO slave:
// register map plus the one-hot state encoding of the irq service FSM.
package gpio_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_DIR  = 2'd1;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    typedef enum logic [10:0] {
        ST_INIT_DIR  = 11'b000_0000_0001,
        ST_INIT_MASK = 11'b000_0000_0010,
        ST_INIT_CLR  = 11'b000_0000_0100,
        ST_IDLE      = 11'b000_0000_1000,
        ST_WR_MASK   = 11'b000_0001_0000,
        ST_RD_EDGE   = 11'b000_0010_0000,
        ST_LAT_EDGE  = 11'b000_0100_0000,
        ST_CLR_EDGE  = 11'b000_1000_0000,
        ST_RD_DATA   = 11'b001_0000_0000,
        ST_LAT_DATA  = 11'b010_0000_0000,
        ST_EMIT      = 11'b100_0000_0000
    } svc_state_e;

endpackage

// File: rtl/gpio_irq_service_master.sv
// Avalon-MM master that initialises a GPIO PIO, then services its irq by
// snapshotting and clearing edge_capture and publishing one event per pass.
module gpio_irq_service_master
    import gpio_pio_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] INIT_DIR  = '0,
    parameter logic [DATA_W-1:0] INIT_MASK = '1,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic [1:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_irq,
    input  logic [DATA_W-1:0] cfg_mask,
    input  logic              cfg_mask_wr,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [DATA_W-1:0] evt_edges,
    output logic [DATA_W-1:0] evt_level,
    output logic [CNT_W-1:0]  evt_count,
    output logic              busy
);

    svc_state_e        state_q, state_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] edge_q, edge_d;
    logic [DATA_W-1:0] level_q, level_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              cs_dec;
    logic              wn_dec;
    logic [1:0]        addr_dec;
    logic [DATA_W-1:0] wdata_dec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT_DIR;
            mask_q  <= '0;
            pend_q  <= 1'b0;
            edge_q  <= '0;
            level_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            edge_q  <= edge_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        pend_d    = pend_q;
        edge_d    = edge_q;
        level_d   = level_q;
        cnt_d     = cnt_q;
        cs_dec    = 1'b0;
        wn_dec    = 1'b1;
        addr_dec  = PIO_ADDR_DATA;
        wdata_dec = '0;

        unique case (state_q)
            ST_INIT_DIR: begin
                cs_dec    = 1'b1;
                wn_dec    = 1'b0;
                addr_dec  = PIO_ADDR_DIR;
                wdata_dec = INIT_DIR;
                state_d   = ST_INIT_MASK;
            end
            ST_INIT_MASK: begin
                cs_dec    = 1'b1;
                wn_dec    = 1'b0;
                addr_dec  = PIO_ADDR_MASK;
                wdata_dec = INIT_MASK;
                state_d   = ST_INIT_CLR;
            end
            ST_INIT_CLR: begin
                cs_dec    = 1'b1;
                wn_dec    = 1'b0;
                addr_dec  = PIO_ADDR_EDGE;
                wdata_dec = '1;
                state_d   = ST_IDLE;
            end
            ST_IDLE: begin
                // Mask update outranks irq so a narrowed mask takes effect first.
                if (pend_q) begin
                    pend_d  = 1'b0;
                    state_d = ST_WR_MASK;
                end else if (avm_irq) begin
                    state_d = ST_RD_EDGE;
                end
            end
            ST_WR_MASK: begin
                cs_dec    = 1'b1;
                wn_dec    = 1'b0;
                addr_dec  = PIO_ADDR_MASK;
                wdata_dec = mask_q;
                state_d   = ST_IDLE;
            end
            ST_RD_EDGE: begin
                cs_dec   = 1'b1;
                addr_dec = PIO_ADDR_EDGE;
                state_d  = ST_LAT_EDGE;
            end
            ST_LAT_EDGE: begin
                cs_dec   = 1'b1;
                addr_dec = PIO_ADDR_EDGE;
                edge_d   = avm_readdata;
                state_d  = (avm_readdata == '0) ? ST_IDLE : ST_CLR_EDGE;
            end
            ST_CLR_EDGE: begin
                cs_dec    = 1'b1;
                wn_dec    = 1'b0;
                addr_dec  = PIO_ADDR_EDGE;
                wdata_dec = '1;
                state_d   = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                cs_dec   = 1'b1;
                addr_dec = PIO_ADDR_DATA;
                state_d  = ST_LAT_DATA;
            end
            ST_LAT_DATA: begin
                cs_dec   = 1'b1;
                addr_dec = PIO_ADDR_DATA;
                level_d  = avm_readdata;
                state_d  = ST_EMIT;
            end
            ST_EMIT: begin
                if (evt_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT_DIR;
        endcase

        // A pulse arriving in the same cycle as the IDLE->WR_MASK hand-off re-arms the update.
        if (cfg_mask_wr) begin
            mask_d = cfg_mask;
            pend_d = 1'b1;
        end
    end

    // The state register sits at INIT_DIR during reset, so hold the bus idle until release.
    assign avm_chipselect = cs_dec & ~reset;
    assign avm_write_n    = wn_dec | reset;
    assign avm_address    = reset ? PIO_ADDR_DATA : addr_dec;
    assign avm_writedata  = reset ? '0 : wdata_dec;

    assign evt_valid = (state_q == ST_EMIT);
    assign evt_edges = edge_q;
    assign evt_level = level_q;
    assign evt_count = cnt_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
